// File: rtl/stepper_pkg.sv
// Shared stepper coil definitions: phase patterns, pattern decode, decoder FSM states.
// Used by both the coil driver and the receive-side phase decoder.
package stepper_pkg;

    localparam logic [3:0] PH_0   = 4'b1000;
    localparam logic [3:0] PH_1   = 4'b1100;
    localparam logic [3:0] PH_2   = 4'b0100;
    localparam logic [3:0] PH_3   = 4'b0110;
    localparam logic [3:0] PH_4   = 4'b0010;
    localparam logic [3:0] PH_5   = 4'b0011;
    localparam logic [3:0] PH_6   = 4'b0001;
    localparam logic [3:0] PH_7   = 4'b1001;
    localparam logic [3:0] PH_OFF = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } dec_state_e;

    typedef struct packed {
        logic       valid;
        logic       zero;
        logic [2:0] idx;
    } phase_dec_t;

    // Map a coil pattern to its half-step index; flags de-energised and illegal.
    function automatic phase_dec_t decode_phase(input logic [3:0] p);
        phase_dec_t r;
        r.valid = 1'b1;
        r.zero  = 1'b0;
        r.idx   = 3'd0;
        case (p)
            PH_0: r.idx = 3'd0;
            PH_1: r.idx = 3'd1;
            PH_2: r.idx = 3'd2;
            PH_3: r.idx = 3'd3;
            PH_4: r.idx = 3'd4;
            PH_5: r.idx = 3'd5;
            PH_6: r.idx = 3'd6;
            PH_7: r.idx = 3'd7;
            PH_OFF: begin
                r.valid = 1'b0;
                r.zero  = 1'b1;
            end
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stepper_phase_sync.sv
// Multi-stage synchroniser for the four asynchronous coil phase lines.
// Clears to de-energised so reset never looks like a phase.
module stepper_phase_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic       clk,
    input  logic       reseteo,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] sync_q [STAGES];
    logic [3:0] sync_d [STAGES];

    // Shift chain: stage 0 takes the raw lines, each later stage the previous one.
    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < int'(STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Chain registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!reseteo) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= 4'b0000;
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/stepper_phase_decoder.sv
// Stepper coil bus monitor: decodes w1..w4 into steps, direction, position,
// step period, stall and sticky sequence-error flags.
module stepper_phase_decoder
    import stepper_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned POS_W        = 16,
    parameter int unsigned PER_W        = 24,
    parameter int unsigned STALL_CYCLES = 50_000_000
) (
    input  logic                    clk,
    input  logic                    reseteo,
    input  logic                    w1,
    input  logic                    w2,
    input  logic                    w3,
    input  logic                    w4,
    input  logic                    clr_pos,
    input  logic                    clr_err,
    output logic signed [POS_W-1:0] pos,
    output logic                    step_pulse,
    output logic                    dir,
    output logic                    half_mode,
    output logic [PER_W-1:0]        period,
    output logic                    period_valid,
    output logic                    stall,
    output logic                    err_skip,
    output logic                    err_invalid,
    output logic [1:0]              state_o
);

    localparam logic [PER_W-1:0] CNT_ONE  = PER_W'(1);
    localparam logic [PER_W-1:0] CNT_MAX  = '1;
    localparam logic [63:0]      STALL_TH = 64'(STALL_CYCLES) - 64'd1;

    logic [3:0] p;
    phase_dec_t dec;

    dec_state_e              state_q, state_d;
    logic [2:0]              last_q, last_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    dir_q, dir_d;
    logic                    half_q, half_d;
    logic                    step_q, step_d;
    logic [PER_W-1:0]        period_q, period_d;
    logic                    pv_q, pv_d;
    logic [PER_W-1:0]        cnt_q, cnt_d;
    logic                    seen_q, seen_d;
    logic                    stall_q, stall_d;
    logic                    eskip_q, eskip_d;
    logic                    einv_q, einv_d;

    logic [2:0]        delta;
    logic signed [2:0] sdelta;
    logic [PER_W-1:0]  cnt_inc;

    stepper_phase_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reseteo (reseteo),
        .d       ({w1, w2, w3, w4}),
        .q       (p)
    );

    assign dec = decode_phase(p);

    // Next-state: phase tracking FSM, position, period and error flags.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        half_d   = half_q;
        step_d   = 1'b0;
        period_d = period_q;
        pv_d     = 1'b0;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        eskip_d  = eskip_q;
        einv_d   = einv_q;

        // 6 and 7 read as -2 and -1 when the 3-bit delta is taken as signed.
        delta   = dec.idx - last_q;
        sdelta  = signed'(delta);
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        // A fresh error below overrides this clear.
        if (clr_err) begin
            eskip_d = 1'b0;
            einv_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (dec.valid) begin
                    last_d  = dec.idx;
                    state_d = ST_TRACK;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                end else if (!dec.zero) begin
                    einv_d  = 1'b1;
                    state_d = ST_FAULT;
                end
            end
            ST_TRACK: begin
                if (dec.zero) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!dec.valid) begin
                    einv_d  = 1'b1;
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                end else begin
                    case (delta)
                        3'd0: cnt_d = cnt_inc;
                        3'd1, 3'd2, 3'd6, 3'd7: begin
                            step_d = 1'b1;
                            pos_d  = pos_q + POS_W'(sdelta);
                            dir_d  = ~delta[2];
                            half_d = delta[0];
                            last_d = dec.idx;
                            if (seen_q) begin
                                period_d = cnt_inc;
                                pv_d     = 1'b1;
                            end
                            seen_d = 1'b1;
                            cnt_d  = '0;
                        end
                        default: begin
                            eskip_d = 1'b1;
                            state_d = ST_FAULT;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end
            ST_FAULT: begin
                if (clr_err) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear beats a coincident step; the pulse still reports the step.
        if (clr_pos) begin
            pos_d = '0;
        end

        stall_d = (state_d == ST_TRACK) && (64'(cnt_d) >= STALL_TH);
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!reseteo) begin
            state_q  <= ST_IDLE;
            last_q   <= 3'd0;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            half_q   <= 1'b0;
            step_q   <= 1'b0;
            period_q <= '0;
            pv_q     <= 1'b0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            stall_q  <= 1'b0;
            eskip_q  <= 1'b0;
            einv_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            half_q   <= half_d;
            step_q   <= step_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            stall_q  <= stall_d;
            eskip_q  <= eskip_d;
            einv_q   <= einv_d;
        end
    end

    assign pos          = pos_q;
    assign step_pulse   = step_q;
    assign dir          = dir_q;
    assign half_mode    = half_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign stall        = stall_q;
    assign err_skip     = eskip_q;
    assign err_invalid  = einv_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Randomised bench for stepper_phase_decoder against a behavioural model.
// Directed test-plan scenarios first, then random phase traffic.
module tb_stepper_phase_decoder;

    localparam int SYNC  = 2;
    localparam int POS_W = 4;
    localparam int PER_W = 8;
    localparam int STALL = 20;
    localparam int PMOD  = 1 << POS_W;
    localparam int PMAX  = (1 << PER_W) - 1;

    localparam logic [3:0] PAT [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    logic                    clk;
    logic                    reseteo;
    logic                    w1, w2, w3, w4;
    logic                    clr_pos, clr_err;
    logic signed [POS_W-1:0] pos;
    logic                    step_pulse, dir, half_mode;
    logic [PER_W-1:0]        period;
    logic                    period_valid, stall;
    logic                    err_skip, err_invalid;
    logic [1:0]              state_o;
    logic [POS_W-1:0]        pos_bits;

    assign pos_bits = pos;

    stepper_phase_decoder #(
        .SYNC_STAGES  (SYNC),
        .POS_W        (POS_W),
        .PER_W        (PER_W),
        .STALL_CYCLES (STALL)
    ) dut (
        .clk          (clk),
        .reseteo      (reseteo),
        .w1           (w1),
        .w2           (w2),
        .w3           (w3),
        .w4           (w4),
        .clr_pos      (clr_pos),
        .clr_err      (clr_err),
        .pos          (pos),
        .step_pulse   (step_pulse),
        .dir          (dir),
        .half_mode    (half_mode),
        .period       (period),
        .period_valid (period_valid),
        .stall        (stall),
        .err_skip     (err_skip),
        .err_invalid  (err_invalid),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_step = 0;
    int n_pv = 0;

    // model: 0 idle, 1 track, 2 fault
    logic [3:0] m_sh [SYNC];
    int m_state, m_last, m_pos, m_per, m_cnt;
    bit m_dir, m_half, m_step, m_pv, m_stall, m_es, m_ei, m_seen;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // -1 illegal, -2 de-energised, else half-step index
    function automatic int idx_of(input logic [3:0] p);
        if (p == 4'b0000) return -2;
        for (int i = 0; i < 8; i++) begin
            if (PAT[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_sh[i] = 4'b0000;
        m_state = 0; m_last = 0; m_pos = 0; m_per = 0; m_cnt = 0;
        m_dir = 0; m_half = 0; m_step = 0; m_pv = 0; m_stall = 0;
        m_es = 0; m_ei = 0; m_seen = 0;
    endtask

    task automatic model_edge();
        logic [3:0] p;
        int ix, d, mv;
        if (!reseteo) begin
            model_reset();
            return;
        end
        p = m_sh[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
        m_sh[0] = {w1, w2, w3, w4};
        ix = idx_of(p);
        m_step = 0;
        m_pv = 0;
        if (m_state == 2) begin
            if (clr_err) begin
                m_es = 0; m_ei = 0; m_state = 0;
            end
        end else if (m_state == 0) begin
            if (ix >= 0) begin
                m_last = ix; m_state = 1; m_cnt = 0; m_seen = 0;
            end else if (ix == -1) begin
                m_ei = 1; m_state = 2;
            end
        end else begin
            if (ix == -2) begin
                m_state = 0; m_cnt = 0;
            end else if (ix == -1) begin
                m_ei = 1; m_state = 2; m_cnt = 0;
            end else begin
                d = (ix - m_last + 8) % 8;
                if (d == 0) begin
                    m_cnt = (m_cnt + 1 > PMAX) ? PMAX : m_cnt + 1;
                end else if (d >= 3 && d <= 5) begin
                    m_es = 1; m_state = 2; m_cnt = 0;
                end else begin
                    mv = (d < 4) ? d : d - 8;
                    m_pos = (m_pos + mv + PMOD) % PMOD;
                    m_dir = (mv > 0);
                    m_half = (mv == 1 || mv == -1);
                    m_last = ix;
                    if (m_seen) begin
                        m_per = (m_cnt + 1 > PMAX) ? PMAX : m_cnt + 1;
                        m_pv = 1;
                    end
                    m_seen = 1;
                    m_cnt = 0;
                    m_step = 1;
                end
            end
        end
        if (clr_pos) m_pos = 0;
        m_stall = (m_state == 1) && (m_cnt >= STALL - 1);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_edge();
        chk("pos", 32'(pos_bits), 32'(m_pos));
        chk("step_pulse", 32'(step_pulse), 32'(m_step));
        chk("dir", 32'(dir), 32'(m_dir));
        chk("half_mode", 32'(half_mode), 32'(m_half));
        chk("period", 32'(period), 32'(m_per));
        chk("period_valid", 32'(period_valid), 32'(m_pv));
        chk("stall", 32'(stall), 32'(m_stall));
        chk("err_skip", 32'(err_skip), 32'(m_es));
        chk("err_invalid", 32'(err_invalid), 32'(m_ei));
        chk("state", 32'(state_o), 32'(m_state));
        if (step_pulse) n_step++;
        if (period_valid) n_pv++;
    endtask

    task automatic setw(input logic [3:0] p);
        {w1, w2, w3, w4} = p;
    endtask

    task automatic hold(input logic [3:0] p, input int n);
        setw(p);
        repeat (n) cyc();
    endtask

    task automatic pulse_err();
        clr_err = 1'b1; cyc(); clr_err = 1'b0;
    endtask

    task automatic pulse_pos();
        clr_pos = 1'b1; cyc(); clr_pos = 1'b0;
    endtask

    task automatic do_reset();
        reseteo = 1'b0; cyc(); cyc(); reseteo = 1'b1;
    endtask

    initial begin
        int ci, r, n;
        logic [3:0] bad;
        reseteo = 1'b0;
        clr_pos = 1'b0;
        clr_err = 1'b0;
        setw(4'b0000);
        model_reset();

        do_reset();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_pos", 32'(pos_bits), 32'd0);

        // full-step CW, 10 cycles apart
        n_step = 0; n_pv = 0;
        hold(4'b1000, 10);
        hold(4'b0100, 10);
        hold(4'b0010, 10);
        hold(4'b0001, 10);
        hold(4'b1000, 10);
        chk("fs_steps", 32'(n_step), 32'd4);
        chk("fs_pv", 32'(n_pv), 32'd3);
        chk("fs_pos_wrap", 32'(pos_bits), 32'h8);
        chk("fs_period", 32'(period), 32'd10);
        chk("fs_dir", 32'(dir), 32'd1);

        // half-step CCW from 1000 with pos cleared
        pulse_pos();
        hold(4'b1001, 5);
        hold(4'b0001, 5);
        hold(4'b0011, 5);
        chk("hs_pos", 32'(pos_bits), 32'hD);
        chk("hs_dir", 32'(dir), 32'd0);
        chk("hs_half", 32'(half_mode), 32'd1);
        hold(4'b0000, 5);
        chk("off_state", 32'(state_o), 32'd0);
        chk("off_pos", 32'(pos_bits), 32'hD);

        // illegal jump, ignored steps, recovery
        hold(4'b1000, 5);
        hold(4'b0010, 5);
        chk("skip_flag", 32'(err_skip), 32'd1);
        chk("skip_state", 32'(state_o), 32'd2);
        chk("skip_pos", 32'(pos_bits), 32'hD);
        hold(4'b0110, 5);
        chk("fault_frozen", 32'(pos_bits), 32'hD);
        hold(4'b0000, 3);
        pulse_err();
        hold(4'b0000, 3);
        chk("clr_state", 32'(state_o), 32'd0);
        chk("clr_skip", 32'(err_skip), 32'd0);

        // invalid pattern with coincident clr_err
        hold(4'b1000, 5);
        setw(4'b1111);
        clr_err = 1'b1;
        repeat (SYNC + 1) cyc();
        clr_err = 1'b0;
        chk("inv_wins", 32'(err_invalid), 32'd1);
        chk("inv_state", 32'(state_o), 32'd2);
        hold(4'b0000, 3);
        pulse_err();
        hold(4'b0000, 3);

        // clr_pos coincident with a CW step at pos 5
        hold(4'b1000, 4);
        pulse_pos();
        for (int i = 1; i <= 5; i++) hold(PAT[i], 3);
        chk("pos5", 32'(pos_bits), 32'd5);
        setw(PAT[6]);
        repeat (SYNC) cyc();
        clr_pos = 1'b1;
        cyc();
        clr_pos = 1'b0;
        chk("clrpos_step", 32'(step_pulse), 32'd1);
        chk("clrpos_pos", 32'(pos_bits), 32'd0);
        hold(PAT[6], 2);
        for (int i = 0; i < 8; i++) hold(PAT[(7 + i) % 8], 3);
        chk("wrap_neg8", 32'(pos_bits), 32'h8);

        // stall and period saturation
        hold(PAT[7], 10);
        chk("no_stall", 32'(stall), 32'd0);
        hold(PAT[7], 20);
        chk("stall_set", 32'(stall), 32'd1);
        hold(PAT[0], 3);
        chk("stall_clr", 32'(stall), 32'd0);
        hold(PAT[0], 300);
        hold(PAT[1], 3);
        chk("per_sat", 32'(period), 32'(PMAX));

        // reset mid-run
        setw(PAT[2]);
        cyc();
        do_reset();
        chk("mid_rst_pos", 32'(pos_bits), 32'd0);
        chk("mid_rst_state", 32'(state_o), 32'd0);

        // random phase traffic
        ci = 0;
        for (int s = 0; s < 400; s++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                case ($urandom_range(0, 4))
                    0: ci = (ci + 1) % 8;
                    1: ci = (ci + 2) % 8;
                    2: ci = (ci + 7) % 8;
                    3: ci = (ci + 6) % 8;
                    default: ci = ci;
                endcase
                setw(PAT[ci]);
            end else if (r < 77) begin
                setw(4'b0000);
            end else if (r < 81) begin
                bad = 4'($urandom_range(0, 15));
                if (idx_of(bad) != -1) bad = 4'b1111;
                setw(bad);
            end else if (r < 87) begin
                ci = (ci + 3 + int'($urandom_range(0, 2))) % 8;
                setw(PAT[ci]);
            end else if (r < 98) begin
                ci = ci;
            end else begin
                reseteo = 1'b0;
            end
            n = ($urandom_range(0, 9) == 0) ? 25 : int'($urandom_range(1, 12));
            for (int k = 0; k < n; k++) begin
                clr_pos = ($urandom_range(0, 40) == 0);
                clr_err = ($urandom_range(0, 12) == 0);
                cyc();
                reseteo = 1'b1;
            end
            clr_pos = 1'b0;
            clr_err = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
